// File: rtl/rpmp_host_initiator.sv
// Host-side initiator for the MSX bridge RATN/ACK/cmd/r handshake bus.
// Captures Z80 cycles for an emulation core, returns read data and writes config words.
module rpmp_host_initiator #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        atn,
    input  logic        ack,
    output logic        ratn,
    output logic [1:0]  cmd,
    input  logic [15:0] r_in,
    output logic [15:0] r_out,
    output logic        r_oe,
    output logic        cyc_valid,
    input  logic        cyc_ready,
    output logic [15:0] cyc_addr,
    output logic [3:0]  cyc_stat,
    output logic [7:0]  cyc_wdata,
    input  logic [7:0]  cyc_rdata,
    input  logic        cfg_valid,
    input  logic [15:0] cfg_word,
    output logic        cfg_ready,
    output logic        busy,
    output logic        timeout_err
);
    localparam int unsigned SYNC_W  = (SYNC_STAGES < 1) ? 1 : SYNC_STAGES;
    localparam int unsigned CNT_MAX = (SETUP_CYC > TIMEOUT_CYC) ? SETUP_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1) + 1;

    localparam logic [1:0] CMD_ADDR = 2'b00;
    localparam logic [1:0] CMD_STAT = 2'b01;
    localparam logic [1:0] CMD_DATA = 2'b10;
    localparam logic [1:0] CMD_CFG  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_STAT, S_PRESENT, S_DATA, S_WAITN, S_CFG
    } state_e;

    typedef enum logic [1:0] {
        P_SETUP, P_STROBE, P_RELEASE
    } phase_e;

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SYNC_W-1:0] atn_sync_q, ack_sync_q;
    logic              atn_s, ack_s;
    logic              atn_done_q, atn_done_d;
    logic              ratn_q, ratn_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [15:0]       r_out_q, r_out_d;
    logic              r_oe_q, r_oe_d;
    logic              cyc_valid_q, cyc_valid_d;
    logic [15:0]       cyc_addr_q, cyc_addr_d;
    logic [3:0]        cyc_stat_q, cyc_stat_d;
    logic [7:0]        cyc_wdata_q, cyc_wdata_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic              busy_q, busy_d;
    logic              timeout_err_q, timeout_err_d;
    logic              tmo_hit, xfer_done, xfer_abort;

    assign atn_s   = atn_sync_q[SYNC_W-1];
    assign ack_s   = ack_sync_q[SYNC_W-1];
    assign tmo_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Input synchronizers and all state/output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            atn_sync_q    <= '0;
            ack_sync_q    <= '0;
            state_q       <= S_IDLE;
            phase_q       <= P_SETUP;
            cnt_q         <= '0;
            atn_done_q    <= 1'b0;
            ratn_q        <= 1'b0;
            cmd_q         <= CMD_ADDR;
            r_out_q       <= '0;
            r_oe_q        <= 1'b0;
            cyc_valid_q   <= 1'b0;
            cyc_addr_q    <= '0;
            cyc_stat_q    <= '0;
            cyc_wdata_q   <= '0;
            cfg_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            atn_sync_q    <= SYNC_W'({atn_sync_q, atn});
            ack_sync_q    <= SYNC_W'({ack_sync_q, ack});
            state_q       <= state_d;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            atn_done_q    <= atn_done_d;
            ratn_q        <= ratn_d;
            cmd_q         <= cmd_d;
            r_out_q       <= r_out_d;
            r_oe_q        <= r_oe_d;
            cyc_valid_q   <= cyc_valid_d;
            cyc_addr_q    <= cyc_addr_d;
            cyc_stat_q    <= cyc_stat_d;
            cyc_wdata_q   <= cyc_wdata_d;
            cfg_ready_q   <= cfg_ready_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q + CNT_W'(1);
        atn_done_d    = atn_done_q & atn_s;
        ratn_d        = ratn_q;
        cmd_d         = cmd_q;
        r_out_d       = r_out_q;
        r_oe_d        = r_oe_q;
        cyc_valid_d   = cyc_valid_q;
        cyc_addr_d    = cyc_addr_q;
        cyc_stat_d    = cyc_stat_q;
        cyc_wdata_d   = cyc_wdata_q;
        cfg_ready_d   = 1'b0;
        timeout_err_d = timeout_err_q;
        xfer_done     = 1'b0;
        xfer_abort    = 1'b0;

        // Shared SETUP/STROBE/RELEASE handshake for every bus command
        if (state_q inside {S_ADDR, S_STAT, S_DATA, S_CFG}) begin
            case (phase_q)
                P_SETUP: begin
                    if ((cnt_q + CNT_W'(1)) >= CNT_W'(SETUP_CYC)) begin
                        phase_d = P_STROBE;
                        ratn_d  = 1'b1;
                        cnt_d   = '0;
                    end
                end
                P_STROBE: begin
                    if (ack_s) begin
                        ratn_d  = 1'b0;
                        phase_d = P_RELEASE;
                        cnt_d   = '0;
                        if (state_q == S_ADDR) begin
                            cyc_addr_d = r_in;
                        end
                        if (state_q == S_STAT) begin
                            cyc_stat_d  = r_in[15:12];
                            cyc_wdata_d = r_in[7:0];
                        end
                    end else if (tmo_hit) begin
                        xfer_abort = 1'b1;
                    end
                end
                P_RELEASE: begin
                    if (!ack_s) begin
                        r_oe_d    = 1'b0;
                        cmd_d     = CMD_ADDR;
                        xfer_done = 1'b1;
                    end else if (tmo_hit) begin
                        xfer_abort = 1'b1;
                    end
                end
                default: phase_d = P_SETUP;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                // A fresh atn assertion always wins over a pending config write
                if (atn_s && !atn_done_q) begin
                    state_d    = S_ADDR;
                    atn_done_d = 1'b1;
                    cmd_d      = CMD_ADDR;
                    r_out_d    = '0;
                    r_oe_d     = 1'b0;
                    phase_d    = P_SETUP;
                    cnt_d      = '0;
                end else if (cfg_valid && !atn_s) begin
                    state_d = S_CFG;
                    cmd_d   = CMD_CFG;
                    r_out_d = cfg_word;
                    r_oe_d  = 1'b1;
                    phase_d = P_SETUP;
                    cnt_d   = '0;
                end
            end
            S_ADDR: begin
                if (xfer_done) begin
                    state_d = S_STAT;
                    cmd_d   = CMD_STAT;
                    phase_d = P_SETUP;
                    cnt_d   = '0;
                end
            end
            S_STAT: begin
                if (xfer_done) begin
                    state_d     = S_PRESENT;
                    cyc_valid_d = 1'b1;
                end
            end
            S_PRESENT: begin
                if (cyc_ready) begin
                    cyc_valid_d = 1'b0;
                    if (!cyc_stat_q[3]) begin
                        state_d = S_DATA;
                        cmd_d   = CMD_DATA;
                        r_out_d = {8'h00, cyc_rdata};
                        r_oe_d  = 1'b1;
                        phase_d = P_SETUP;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_WAITN;
                    end
                end
            end
            S_DATA: begin
                if (xfer_done) begin
                    state_d = S_WAITN;
                end
            end
            S_WAITN: begin
                if (!atn_s) begin
                    state_d = S_IDLE;
                end
            end
            S_CFG: begin
                if (xfer_done) begin
                    state_d     = S_IDLE;
                    cfg_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bridge stopped answering: drop the bus and return to idle
        if (xfer_abort) begin
            timeout_err_d = 1'b1;
            ratn_d        = 1'b0;
            r_oe_d        = 1'b0;
            cmd_d         = CMD_ADDR;
            cyc_valid_d   = 1'b0;
            state_d       = S_IDLE;
            phase_d       = P_SETUP;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign ratn        = ratn_q;
    assign cmd         = cmd_q;
    assign r_out       = r_out_q;
    assign r_oe        = r_oe_q;
    assign cyc_valid   = cyc_valid_q;
    assign cyc_addr    = cyc_addr_q;
    assign cyc_stat    = cyc_stat_q;
    assign cyc_wdata   = cyc_wdata_q;
    assign cfg_ready   = cfg_ready_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rpmp_host_initiator.sv
// Directed bench for rpmp_host_initiator: behavioural bridge with a transfer scoreboard.
module tb_rpmp_host_initiator;
    logic        clk = 1'b0;
    logic        rst;
    logic        atn;
    logic        ack = 1'b0;
    logic        ratn;
    logic [1:0]  cmd;
    logic [15:0] r_in = 16'h0000;
    logic [15:0] r_out;
    logic        r_oe;
    logic        cyc_valid;
    logic        cyc_ready;
    logic [15:0] cyc_addr;
    logic [3:0]  cyc_stat;
    logic [7:0]  cyc_wdata;
    logic [7:0]  cyc_rdata;
    logic        cfg_valid;
    logic [15:0] cfg_word;
    logic        cfg_ready;
    logic        busy;
    logic        timeout_err;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [15:0] rout;
        logic        oe;
    } xfer_t;

    xfer_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          oe_viol = 0;
    int          rout_viol = 0;
    logic        no_ack = 1'b0;
    logic [15:0] br_addr = 16'h0000;
    logic [15:0] br_stat = 16'h0000;
    logic        ratn_prev = 1'b0;
    logic [15:0] rout_prev = 16'h0000;

    rpmp_host_initiator #(
        .SYNC_STAGES(2),
        .SETUP_CYC  (2),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .atn        (atn),
        .ack        (ack),
        .ratn       (ratn),
        .cmd        (cmd),
        .r_in       (r_in),
        .r_out      (r_out),
        .r_oe       (r_oe),
        .cyc_valid  (cyc_valid),
        .cyc_ready  (cyc_ready),
        .cyc_addr   (cyc_addr),
        .cyc_stat   (cyc_stat),
        .cyc_wdata  (cyc_wdata),
        .cyc_rdata  (cyc_rdata),
        .cfg_valid  (cfg_valid),
        .cfg_word   (cfg_word),
        .cfg_ready  (cfg_ready),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Bridge: checks each strobe against the scoreboard, acks 5 clk later, releases 5 clk after ratn falls
    always @(posedge ratn) begin
        xfer_t e;
        #1;
        check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("xfer_cmd", 32'(cmd), 32'(e.cmd));
            check("xfer_rout", 32'(r_out), 32'(e.rout));
            check("xfer_oe", 32'(r_oe), 32'(e.oe));
        end
        if (!no_ack) begin
            repeat (5) @(posedge clk);
            #1;
            r_in = (cmd == 2'b00) ? br_addr : (cmd == 2'b01) ? br_stat : 16'h0000;
            ack  = 1'b1;
            for (int i = 0; i < 200 && ratn; i++) @(posedge clk);
            check("ratn_release", 32'(ratn), 32'd0);
            repeat (5) @(posedge clk);
            #1;
            ack = 1'b0;
        end
    end

    // Bus rule monitor: pad drive only for cmd 1x, r_out frozen while ratn high
    always @(negedge clk) begin
        if (r_oe && !cmd[1]) oe_viol <= oe_viol + 1;
        if (ratn && ratn_prev && (r_out !== rout_prev)) rout_viol <= rout_viol + 1;
        ratn_prev <= ratn;
        rout_prev <= r_out;
    end

    task automatic wait_valid();
        int n = 0;
        while (!cyc_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("cyc_valid_seen", 32'(cyc_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("idle_seen", 32'(busy), 32'd0);
    endtask

    task automatic wait_cfg_ready();
        int n = 0;
        while (!cfg_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("cfg_ready_seen", 32'(cfg_ready), 32'd1);
    endtask

    task automatic push_addr_stat(input logic [15:0] a, input logic [3:0] st, input logic [7:0] wd,
                                  input logic [7:0] rd);
        br_addr = a;
        br_stat = {st, 4'h0, wd};
        exp_q.push_back('{cmd: 2'b00, rout: 16'h0000, oe: 1'b0});
        exp_q.push_back('{cmd: 2'b01, rout: 16'h0000, oe: 1'b0});
        if (!st[3]) exp_q.push_back('{cmd: 2'b10, rout: {8'h00, rd}, oe: 1'b1});
    endtask

    task automatic accept(input logic [15:0] a, input logic [3:0] st, input logic [7:0] wd,
                          input logic [7:0] rd);
        wait_valid();
        check("cyc_addr", 32'(cyc_addr), 32'(a));
        check("cyc_stat", 32'(cyc_stat), 32'(st));
        check("cyc_wdata", 32'(cyc_wdata), 32'(wd));
        cyc_rdata = rd;
        cyc_ready = 1'b1;
        @(negedge clk);
        cyc_ready = 1'b0;
        check("cyc_valid_drop", 32'(cyc_valid), 32'd0);
    endtask

    task automatic run_cycle(input logic [15:0] a, input logic [3:0] st, input logic [7:0] wd,
                             input logic [7:0] rd);
        push_addr_stat(a, st, wd, rd);
        atn = 1'b1;
        accept(a, st, wd, rd);
        atn = 1'b0;
        wait_idle();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        int pulses;
        rst       = 1'b1;
        atn       = 1'b0;
        cyc_ready = 1'b0;
        cyc_rdata = 8'h00;
        cfg_valid = 1'b0;
        cfg_word  = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_ratn", 32'(ratn), 32'd0);
        check("rst_cmd", 32'(cmd), 32'd0);
        check("rst_rout", 32'(r_out), 32'd0);
        check("rst_roe", 32'(r_oe), 32'd0);
        check("rst_cyc_valid", 32'(cyc_valid), 32'd0);
        check("rst_cyc_addr", 32'(cyc_addr), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Z80 write cycle: cmd 00 then 01, no data return
        run_cycle(16'h4000, 4'hC, 8'h5A, 8'h00);
        // Z80 read cycle: core data goes back on cmd 10
        run_cycle(16'h8001, 4'h4, 8'h00, 8'hC3);

        // Config write while atn low
        exp_q.push_back('{cmd: 2'b11, rout: 16'h0398, oe: 1'b1});
        cfg_word  = 16'h0398;
        cfg_valid = 1'b1;
        wait_cfg_ready();
        cfg_valid = 1'b0;
        @(negedge clk);
        check("cfg_ready_pulse", 32'(cfg_ready), 32'd0);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (cfg_ready) pulses++;
        end
        check("cfg_no_repeat", 32'(pulses), 32'd0);
        check("cfg_sb_empty", 32'(exp_q.size()), 32'd0);

        // cfg_valid lands on the same cycle as the synchronized atn rise
        push_addr_stat(16'h1234, 4'hC, 8'hA5, 8'h00);
        exp_q.push_back('{cmd: 2'b11, rout: 16'h8A1F, oe: 1'b1});
        cfg_word = 16'h8A1F;
        atn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cfg_valid = 1'b1;
        accept(16'h1234, 4'hC, 8'hA5, 8'h00);
        atn = 1'b0;
        wait_cfg_ready();
        cfg_valid = 1'b0;
        wait_idle();
        check("prio_sb_empty", 32'(exp_q.size()), 32'd0);

        // Bridge never acks: abort after 16 cycles in STROBE
        no_ack = 1'b1;
        exp_q.push_back('{cmd: 2'b00, rout: 16'h0000, oe: 1'b0});
        atn = 1'b1;
        n = 0;
        while (!ratn && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("tmo_strobe_start", 32'(ratn), 32'd1);
        hi = 0;
        n  = 0;
        while (ratn && n < 100) begin
            hi++;
            @(negedge clk);
            n++;
        end
        check("tmo_strobe_len", 32'(hi), 32'd16);
        check("tmo_err", 32'(timeout_err), 32'd1);
        check("tmo_ratn", 32'(ratn), 32'd0);
        check("tmo_busy", 32'(busy), 32'd0);
        check("tmo_cyc_valid", 32'(cyc_valid), 32'd0);
        atn    = 1'b0;
        no_ack = 1'b0;
        repeat (5) @(negedge clk);
        run_cycle(16'hBEEF, 4'hC, 8'h11, 8'h00);
        check("tmo_sticky", 32'(timeout_err), 32'd1);

        // Reset pulse during the cmd 10 strobe
        push_addr_stat(16'h2002, 4'h4, 8'h00, 8'h5E);
        atn = 1'b1;
        accept(16'h2002, 4'h4, 8'h00, 8'h5E);
        n = 0;
        while (!(ratn && cmd == 2'b10) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_data_strobe", 32'(ratn && cmd == 2'b10), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ratn", 32'(ratn), 32'd0);
        check("arst_roe", 32'(r_oe), 32'd0);
        check("arst_cyc_valid", 32'(cyc_valid), 32'd0);
        check("arst_timeout", 32'(timeout_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        atn = 1'b0;
        repeat (30) @(negedge clk);
        check("arst_sb_empty", 32'(exp_q.size()), 32'd0);
        run_cycle(16'h3003, 4'hC, 8'h77, 8'h00);

        check("oe_only_cmd1x", 32'(oe_viol), 32'd0);
        check("rout_stable_strobe", 32'(rout_viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
